// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths, canonical constants and operand classification.
// Used by the iterative divider and the combinational multiplier.
package fp32_pkg;

    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MAN_W    = 23;
    localparam int FP32_EXP_BIAS = 127;

    localparam logic [31:0] FP32_QNAN    = 32'h7fc0_0000;
    localparam logic [31:0] FP32_POS_INF = 32'h7f80_0000;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp32_class_t;

    // Subnormals (exp==0, man!=0) classify as zero: they are flushed.
    function automatic fp32_class_t fp32_classify(input logic [31:0] x);
        fp32_class_t c;
        c.is_nan  = (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
        c.is_inf  = (x[30:23] == 8'hff) && (x[22:0] == 23'h0);
        c.is_zero = (x[30:23] == 8'h00);
        return c;
    endfunction

endpackage

// File: rtl/fp32_div_mant_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
// Purely combinational; the divider iterates it once per CALC cycle.
module fp32_div_mant_step (
    input  logic [24:0] rem,
    input  logic [23:0] mb,
    output logic [24:0] rem_next,
    output logic        qbit
);

    logic [24:0] diff;

    assign qbit = (rem >= {1'b0, mb});
    assign diff = qbit ? (rem - {1'b0, mb}) : rem;
    // diff is always below mb < 2^24, so dropping bit 24 loses nothing.
    assign rem_next = {diff[23:0], 1'b0};

endmodule

// File: rtl/fp32_div_iter.sv
// Multicycle FP32 divider (a / b): radix-2 restoring mantissa division, one quotient bit
// per cycle, flush-to-zero and truncation, valid/ready handshake on input and output.
module fp32_div_iter
    import fp32_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'h7fc0_0000,
    parameter int          QBITS     = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [4:0] LAST_STEP = 5'(QBITS - 1);

    logic [1:0]        state_q, state_d;
    logic [4:0]        step_q, step_d;
    logic [QBITS-1:0]  rem_q, rem_d;
    logic [QBITS-1:0]  quo_q, quo_d;
    logic [23:0]       mb_q, mb_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [31:0]       result_q, result_d;

    logic              accept;
    fp32_class_t       cls_a, cls_b;
    logic              is_special;
    logic [31:0]       special_res;
    logic [QBITS-1:0]  rem_next;
    logic              qbit;
    logic signed [9:0] exp_adj;
    logic [22:0]       man_norm;
    logic [31:0]       norm_res;

    assign accept = in_valid && in_ready;
    assign cls_a  = fp32_classify(a);
    assign cls_b  = fp32_classify(b);

    fp32_div_mant_step u_step (
        .rem      (rem_q),
        .mb       (mb_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Special operands resolve in the accept cycle; order matters where classes overlap.
    always_comb begin
        is_special  = cls_a.is_nan || cls_b.is_nan || cls_a.is_inf || cls_b.is_inf
                   || cls_a.is_zero || cls_b.is_zero;
        special_res = 32'h0;
        if (cls_a.is_nan || cls_b.is_nan || (cls_a.is_inf && cls_b.is_inf)
                || (cls_a.is_zero && cls_b.is_zero)) begin
            special_res = NAN_VALUE;
        end else if (cls_b.is_zero || cls_a.is_inf) begin
            special_res = {a[31] ^ b[31], FP32_POS_INF[30:0]};
        end else if (cls_a.is_zero) begin
            special_res = 32'h0;
        end else if (cls_b.is_inf) begin
            special_res = {a[31] ^ b[31], 31'h0};
        end
    end

    // Quotient lies in (0.5, 2): bit QBITS-1 tells whether a 1-bit renormalisation is needed.
    always_comb begin
        if (quo_q[QBITS-1]) begin
            exp_adj  = exp_q;
            man_norm = quo_q[23:1];
        end else begin
            exp_adj  = exp_q - 10'sd1;
            man_norm = quo_q[22:0];
        end
        if (exp_adj >= 10'sd255) begin
            norm_res = {sign_q, FP32_POS_INF[30:0]};
        end else if (exp_adj <= 10'sd0) begin
            norm_res = {sign_q, 31'h0};
        end else begin
            norm_res = {sign_q, exp_adj[7:0], man_norm};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each comb process assigns a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_special ? DONE : CALC;
            CALC: if (step_q == LAST_STEP) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign result = result_q;

    always_comb begin
        step_d   = step_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    step_d = 5'd0;
                    rem_d  = {1'b0, 1'b1, a[22:0]};
                    quo_d  = '0;
                    mb_d   = {1'b1, b[22:0]};
                    sign_d = a[31] ^ b[31];
                    exp_d  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                           + 10'(FP32_EXP_BIAS);
                    if (is_special) result_d = special_res;
                end
            end
            CALC: begin
                step_d = step_q + 5'd1;
                rem_d  = rem_next;
                quo_d  = {quo_q[QBITS-2:0], qbit};
            end
            NORM: result_d = norm_res;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= 5'd0;
            rem_q    <= '0;
            quo_q    <= '0;
            mb_q     <= 24'h0;
            exp_q    <= 10'sd0;
            sign_q   <= 1'b0;
            result_q <= 32'h0;
        end else begin
            step_q   <= step_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_fp32_div_iter.sv
// Scoreboard bench for fp32_div_iter: expected quotients queued at issue, compared on output,
// with latency, back-pressure, busy-ignore and mid-operation reset scenarios.
module tb_fp32_div_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    fp32_div_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one op, optionally poke in_valid mid-calculation, hold back-pressure, then drain.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] exp_res, input int exp_lat, input int hold,
                          input bit pulse);
        int          lat;
        logic [31:0] want;
        logic        stable;
        @(negedge clk);
        check({tag, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            if (pulse && lat == 5) begin
                in_valid = 1'b1;
                check({tag, "_busy_ready"}, {31'h0, in_ready}, 32'h0);
            end
            @(posedge clk);
            #1;
            lat++;
            if (pulse && lat == 6) in_valid = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        want = exp_q.pop_front();
        check({tag, "_result"}, result, want);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (result !== want || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, {31'h0, stable}, 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_drain_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        #12;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 10, 1'b1);
        run_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, 0, 1'b0);
        run_op("neg_one_div_three", 32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 27, 0, 1'b0);

        run_op("pos_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 1'b0);
        run_op("neg_div_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1, 0, 1'b0);
        run_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0, 1'b0);
        run_op("inf_div_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0, 1'b0);
        run_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, 0, 1'b0);
        run_op("fin_div_inf", 32'h3F800000, 32'h7F800000, 32'h00000000, 1, 3, 1'b0);

        run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 27, 0, 1'b0);
        run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 27, 0, 1'b0);
        run_op("neg_underflow", 32'h80800000, 32'h7F000000, 32'h80000000, 27, 0, 1'b0);

        // Abort an operation partway through CALC.
        @(negedge clk);
        a        = 32'h40C00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        exp_q.push_back(32'h40400000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        check("abort_in_ready", {31'h0, in_ready}, 32'h1);
        check("abort_result", result, 32'h0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_stale", {31'h0, seen}, 32'h0);

        run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 27, 0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
